instruction_fetch_sequencer: RTL and testbench
==============================================

// Module: instruction_fetch_sequencer
// PURPOSE
// Writer side of the 16-bit instruction register: fetches one instruction as two bytes from
// byte-wide memory at PC (low half) and PC+1 (high half), driving IRWrite/IRLH/IRData so the
// IR captures IROut[7:0] then IROut[15:8]. Owns the program counter, which advances by 2 per fetch.
// Sits between the memory port and the IR; started by the control unit, reports Done/Error.
// PARAMETERS
// ADDR_WIDTH      16      width of PC / MemAddr
// RESET_PC        0       PC value after Reset
// TIMEOUT_CYCLES  15      max cycles waiting for MemReady per byte before Error (1..255)
// PORTS
// Clock     in   1           rising-edge clock
// Reset     in   1           synchronous, active-high reset
// Start     in   1           request one instruction fetch; sampled only in IDLE
// PCLoad    in   1           load PC from PCIn; honoured only in IDLE
// PCIn      in   ADDR_WIDTH  new PC value
// MemRead   out  1           memory read request, held until MemReady
// MemAddr   out  ADDR_WIDTH  byte address of current request
// MemData   in   8           read data, valid when MemReady=1
// MemReady  in   1           read-data valid strobe
// IRData    out  8           byte to the instruction register
// IRWrite   out  1           one-cycle write strobe to the instruction register
// IRLH      out  1           0 = low half IR[7:0], 1 = high half IR[15:8]
// PC        out  ADDR_WIDTH  current program counter
// Busy      out  1           1 in FETCH_LO/FETCH_HI
// Done      out  1           one-cycle pulse when high byte written
// Error     out  1           sticky timeout flag; cleared by Reset or next accepted Start
// BEHAVIOUR
// - Reset (any state, incl. mid-fetch): state=IDLE, PC=RESET_PC, MemRead=0, MemAddr=0,
//   IRData=0, IRWrite=0, IRLH=0, Busy=0, Done=0, Error=0, timeout counter=0. Reset wins over all.
// - States: IDLE, FETCH_LO, FETCH_HI, WRITE_HI. All outputs registered.
// - IDLE: PCLoad=1 -> PC<=PCIn next edge. Start=1 (PCLoad=0) -> FETCH_LO, MemRead=1, MemAddr=PC,
//   Error<=0. PCLoad and Start together: load takes priority, Start ignored that cycle.
// - FETCH_LO: hold MemRead=1/MemAddr=PC. On MemReady=1: IRData<=MemData, IRWrite<=1, IRLH<=0,
//   MemAddr<=PC+1, counter<=0, -> FETCH_HI. MemReady in the same cycle as entry counts.
// - FETCH_HI: MemRead=1, MemAddr=PC+1 (mod 2^ADDR_WIDTH). On MemReady=1: IRData<=MemData,
//   IRWrite<=1, IRLH<=1, MemRead<=0, PC<=PC+2 (wraps), -> WRITE_HI.
// - WRITE_HI: Done=1 for exactly this cycle (coincides with high-byte IRWrite pulse), -> IDLE.
// - IRWrite is a single-cycle pulse per byte; never two consecutive pulses with same IRLH.
// - Latency: zero-wait memory -> Start edge to Done = 3 cycles; each wait cycle adds 1.
// - Timeout: counter increments each FETCH_LO/FETCH_HI cycle without MemReady; reaching
//   TIMEOUT_CYCLES -> Error<=1, MemRead<=0, -> IDLE; PC unchanged; no IRWrite for pending byte.
// - MemReady while MemRead=0 is ignored. Start/PCLoad outside IDLE ignored (not queued).
// - PC wrap: PC=2^ADDR_WIDTH-1 fetches low at FFFF, high at 0000, PC becomes 0001.
// TESTING
// 1 Reset mid FETCH_HI (PC=0x0010) -> next cycle IDLE, PC=RESET_PC, MemRead=0, no IRWrite/Done.
// 2 PC=0x0100, zero-wait mem [0x100]=0x34,[0x101]=0x12 -> IRWrite LH=0 data 0x34, then LH=1
//   data 0x12 with Done; IR reads 0x1234; PC=0x0102.
// 3 Same with 2 wait cycles per byte -> MemAddr held stable while waiting; Done at cycle 7.
// 4 MemReady never asserted -> Error=1 after 15 cycles, PC unchanged, no IRWrite; next Start clears Error.
// 5 PC=0xFFFF fetch -> MemAddr 0xFFFF then 0x0000; PC=0x0001.
// 6 PCLoad=1,PCIn=0x0200 with Start=1 in IDLE -> PC=0x0200, no fetch; Start next cycle fetches 0x200.

Source files
------------

// File: rtl/instruction_fetch_sequencer.sv
// Fetches one 16-bit instruction as two byte reads (PC, then PC+1) and streams
// each byte into the instruction register; owns the PC and flags read timeouts.
module instruction_fetch_sequencer #(
  parameter int                    ADDR_WIDTH     = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0,
  parameter int                    TIMEOUT_CYCLES = 15
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  PCLoad,
  input  logic [ADDR_WIDTH-1:0] PCIn,
  output logic                  MemRead,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  input  logic [7:0]            MemData,
  input  logic                  MemReady,
  output logic [7:0]            IRData,
  output logic                  IRWrite,
  output logic                  IRLH,
  output logic [ADDR_WIDTH-1:0] PC,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH_LO = 2'd1,
    FETCH_HI = 2'd2,
    WRITE_HI = 2'd3
  } state_t;

  localparam logic [7:0]            TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] PC_INC1  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] PC_INC2  = ADDR_WIDTH'(2);

  state_t                  state_q,    state_d;
  logic [ADDR_WIDTH-1:0]   pc_q,       pc_d;
  logic                    mem_read_q, mem_read_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]              ir_data_q,  ir_data_d;
  logic                    ir_write_q, ir_write_d;
  logic                    ir_lh_q,    ir_lh_d;
  logic                    busy_q,     busy_d;
  logic                    done_q,     done_d;
  logic                    error_q,    error_d;
  logic [7:0]              tmo_cnt_q,  tmo_cnt_d;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      mem_read_q <= 1'b0;
      mem_addr_q <= '0;
      ir_data_q  <= '0;
      ir_write_q <= 1'b0;
      ir_lh_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      tmo_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_read_q <= mem_read_d;
      mem_addr_q <= mem_addr_d;
      ir_data_q  <= ir_data_d;
      ir_write_q <= ir_write_d;
      ir_lh_q    <= ir_lh_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mem_read_d = mem_read_q;
    mem_addr_d = mem_addr_q;
    ir_data_d  = ir_data_q;
    ir_write_d = 1'b0;
    ir_lh_d    = ir_lh_q;
    done_d     = 1'b0;
    error_d    = error_q;
    tmo_cnt_d  = tmo_cnt_q;

    case (state_q)
      IDLE: begin
        // A PC load shadows a simultaneous Start; the fetch must be re-requested.
        if (PCLoad) begin
          pc_d = PCIn;
        end else if (Start) begin
          state_d    = FETCH_LO;
          mem_read_d = 1'b1;
          mem_addr_d = pc_q;
          error_d    = 1'b0;
          tmo_cnt_d  = '0;
        end
      end

      FETCH_LO: begin
        if (MemReady) begin
          ir_data_d  = MemData;
          ir_write_d = 1'b1;
          ir_lh_d    = 1'b0;
          mem_addr_d = pc_q + PC_INC1;
          tmo_cnt_d  = '0;
          state_d    = FETCH_HI;
        end else if (tmo_cnt_q == TMO_LAST) begin
          error_d    = 1'b1;
          mem_read_d = 1'b0;
          tmo_cnt_d  = '0;
          state_d    = IDLE;
        end else begin
          tmo_cnt_d  = tmo_cnt_q + 8'd1;
        end
      end

      FETCH_HI: begin
        // Done is raised together with the high-byte strobe so both land in WRITE_HI.
        if (MemReady) begin
          ir_data_d  = MemData;
          ir_write_d = 1'b1;
          ir_lh_d    = 1'b1;
          mem_read_d = 1'b0;
          pc_d       = pc_q + PC_INC2;
          tmo_cnt_d  = '0;
          done_d     = 1'b1;
          state_d    = WRITE_HI;
        end else if (tmo_cnt_q == TMO_LAST) begin
          error_d    = 1'b1;
          mem_read_d = 1'b0;
          tmo_cnt_d  = '0;
          state_d    = IDLE;
        end else begin
          tmo_cnt_d  = tmo_cnt_q + 8'd1;
        end
      end

      WRITE_HI: begin
        state_d = IDLE;
      end

      default: begin
        state_d    = IDLE;
        mem_read_d = 1'b0;
      end
    endcase

    busy_d = (state_d == FETCH_LO) || (state_d == FETCH_HI);
  end

  assign MemRead = mem_read_q;
  assign MemAddr = mem_addr_q;
  assign IRData  = ir_data_q;
  assign IRWrite = ir_write_q;
  assign IRLH    = ir_lh_q;
  assign PC      = pc_q;
  assign Busy    = busy_q;
  assign Done    = done_q;
  assign Error   = error_q;

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Directed bench for instruction_fetch_sequencer: a table of fetches against a
// byte memory model with configurable wait states, plus multi-cycle corner sequences.
module tb_instruction_fetch_sequencer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic        PCLoad;
  logic [15:0] PCIn;
  logic        MemRead;
  logic [15:0] MemAddr;
  logic [7:0]  MemData;
  logic        MemReady;
  logic [7:0]  IRData;
  logic        IRWrite;
  logic        IRLH;
  logic [15:0] PC;
  logic        Busy;
  logic        Done;
  logic        Error;

  instruction_fetch_sequencer #(
    .ADDR_WIDTH    (16),
    .RESET_PC      (16'h0000),
    .TIMEOUT_CYCLES(15)
  ) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Start   (Start),
    .PCLoad  (PCLoad),
    .PCIn    (PCIn),
    .MemRead (MemRead),
    .MemAddr (MemAddr),
    .MemData (MemData),
    .MemReady(MemReady),
    .IRData  (IRData),
    .IRWrite (IRWrite),
    .IRLH    (IRLH),
    .PC      (PC),
    .Busy    (Busy),
    .Done    (Done),
    .Error   (Error)
  );

  always #5 Clock = ~Clock;

  // Byte memory: answers a held request after wait_cfg stalled cycles.
  logic [7:0] mem [0:65535];
  int         wait_cfg = 0;
  int         wait_ctr = 0;
  logic       mem_en = 1'b1;
  logic       force_ready = 1'b0;

  assign MemReady = force_ready | (mem_en && MemRead && (wait_ctr >= wait_cfg));
  assign MemData  = mem[MemAddr];

  always @(posedge Clock) begin
    if (MemRead && !MemReady) wait_ctr <= wait_ctr + 1;
    else                      wait_ctr <= 0;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Follows one fetch from just after the Start edge until Done (bounded).
  task automatic capture_fetch(input logic [15:0] lo_addr, input logic [15:0] hi_addr,
                               output int done_n, output logic [15:0] ir,
                               output int nwr, output logic [1:0] lh_seq,
                               output int addr_bad);
    int n;
    n        = 0;
    done_n   = -1;
    ir       = 16'h0000;
    nwr      = 0;
    lh_seq   = 2'b00;
    addr_bad = 0;
    while (done_n < 0 && n < 40) begin
      step();
      n++;
      if (IRWrite) begin
        if (IRLH) ir[15:8] = IRData;
        else      ir[7:0]  = IRData;
        lh_seq = {lh_seq[0], IRLH};
        nwr++;
      end
      if (Done) begin
        done_n = n;
        if (!(IRWrite && IRLH)) addr_bad++;
      end else if (MemRead && MemAddr !== ((nwr == 0) ? lo_addr : hi_addr)) begin
        addr_bad++;
      end
    end
  endtask

  typedef struct {
    logic        load;
    logic [15:0] pc;
    int          waits;
    logic [15:0] hi_addr;
    logic [15:0] exp_ir;
    logic [15:0] exp_pc;
    int          exp_done;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int          done_n;
    int          nwr;
    int          addr_bad;
    int          seen;
    logic [15:0] ir;
    logic [1:0]  lh_seq;

    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    mem[16'h0100] = 8'h34; mem[16'h0101] = 8'h12;
    mem[16'hFFFF] = 8'h78; mem[16'h0000] = 8'h56;
    mem[16'h0300] = 8'h9A; mem[16'h0301] = 8'hBC;
    mem[16'h0302] = 8'hEF; mem[16'h0303] = 8'h01;
    mem[16'h0200] = 8'hCD; mem[16'h0201] = 8'hAB;
    mem[16'h0400] = 8'h44; mem[16'h0401] = 8'h55;
    mem[16'h0010] = 8'h11; mem[16'h0011] = 8'h22;

    // Done cycle counts the Start cycle as cycle 1.
    vecs[0] = '{1'b1, 16'h0100, 0, 16'h0101, 16'h1234, 16'h0102, 3};
    vecs[1] = '{1'b1, 16'h0100, 2, 16'h0101, 16'h1234, 16'h0102, 7};
    vecs[2] = '{1'b1, 16'hFFFF, 0, 16'h0000, 16'h5678, 16'h0001, 3};
    vecs[3] = '{1'b1, 16'h0300, 1, 16'h0301, 16'hBC9A, 16'h0302, 5};
    vecs[4] = '{1'b0, 16'h0302, 3, 16'h0303, 16'h01EF, 16'h0304, 9};

    Reset  = 1'b1;
    Start  = 1'b0;
    PCLoad = 1'b0;
    PCIn   = 16'h0000;
    step();
    step();
    check("reset_pc", 32'(PC), 32'h0000);
    check("reset_ctl", 32'({MemRead, IRWrite, IRLH, Busy, Done, Error}), 32'h0);
    check("reset_data", 32'({MemAddr, IRData}), 32'h0);
    Reset = 1'b0;
    step();

    for (int i = 0; i < 5; i++) begin
      wait_cfg = vecs[i].waits;
      if (vecs[i].load) begin
        PCLoad = 1'b1;
        PCIn   = vecs[i].pc;
        step();
        PCLoad = 1'b0;
      end
      check($sformatf("v%0d_pc_before", i), 32'(PC), 32'(vecs[i].pc));
      Start = 1'b1;
      step();
      Start = 1'b0;
      check($sformatf("v%0d_start", i), 32'({Busy, MemRead, MemAddr}), 32'({2'b11, vecs[i].pc}));
      capture_fetch(vecs[i].pc, vecs[i].hi_addr, done_n, ir, nwr, lh_seq, addr_bad);
      $display("vec %0d: pc=0x%04h waits=%0d ir=0x%04h done_cycle=%0d", i, vecs[i].pc,
               vecs[i].waits, ir, done_n + 1);
      check($sformatf("v%0d_done_cycle", i), 32'(done_n + 1), 32'(vecs[i].exp_done));
      check($sformatf("v%0d_ir", i), 32'(ir), 32'(vecs[i].exp_ir));
      check($sformatf("v%0d_pc_after", i), 32'(PC), 32'(vecs[i].exp_pc));
      check($sformatf("v%0d_writes", i), 32'({nwr[3:0], lh_seq}), 32'({4'd2, 2'b01}));
      check($sformatf("v%0d_addr_stable", i), 32'(addr_bad), 32'd0);
      step();
      check($sformatf("v%0d_idle", i), 32'({Done, Busy, IRWrite, MemRead}), 32'h0);
    end

    // PCLoad and Start together: load wins, fetch only on the following Start.
    wait_cfg = 0;
    PCLoad   = 1'b1;
    PCIn     = 16'h0200;
    Start    = 1'b1;
    step();
    check("load_start_pc", 32'({PC, MemRead, Busy}), 32'({16'h0200, 2'b00}));
    PCLoad = 1'b0;
    step();
    Start = 1'b0;
    check("load_start_fetch", 32'({MemRead, MemAddr}), 32'({1'b1, 16'h0200}));
    capture_fetch(16'h0200, 16'h0201, done_n, ir, nwr, lh_seq, addr_bad);
    $display("load+start: ir=0x%04h done_cycle=%0d", ir, done_n + 1);
    check("load_start_ir", 32'({ir, PC}), 32'({16'hABCD, 16'h0202}));
    check("load_start_done", 32'(done_n + 1), 32'd3);
    step();

    // MemReady while idle must not produce a write.
    force_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (IRWrite || Busy || MemRead) seen++;
    end
    force_ready = 1'b0;
    check("idle_ready_ignored", 32'({seen[7:0], PC}), 32'({8'd0, 16'h0202}));

    // Timeout: memory never answers.
    PCLoad = 1'b1;
    PCIn   = 16'h0400;
    step();
    PCLoad = 1'b0;
    mem_en = 1'b0;
    Start  = 1'b1;
    step();
    Start = 1'b0;
    nwr = 0;
    for (int n = 1; n <= 15; n++) begin
      step();
      if (IRWrite) nwr++;
      if (n == 14) check("tmo_pre", 32'({Error, MemRead}), 32'b01);
    end
    $display("timeout: error=%0b pc=0x%04h writes=%0d", Error, PC, nwr);
    check("tmo_err", 32'({Error, MemRead, Busy}), 32'b100);
    check("tmo_pc_nowrite", 32'({PC, nwr[7:0]}), 32'({16'h0400, 8'd0}));
    step();
    check("tmo_sticky", 32'(Error), 32'd1);
    mem_en = 1'b1;
    Start  = 1'b1;
    step();
    Start = 1'b0;
    check("tmo_clear", 32'({Error, Busy}), 32'b01);
    capture_fetch(16'h0400, 16'h0401, done_n, ir, nwr, lh_seq, addr_bad);
    $display("after timeout: ir=0x%04h done_cycle=%0d", ir, done_n + 1);
    check("tmo_refetch", 32'({ir, PC}), 32'({16'h5544, 16'h0402}));
    step();

    // Reset while waiting for the high byte.
    PCLoad = 1'b1;
    PCIn   = 16'h0010;
    step();
    PCLoad   = 1'b0;
    wait_cfg = 3;
    Start    = 1'b1;
    step();
    Start = 1'b0;
    seen = 0;
    for (int k = 0; k < 10 && seen == 0; k++) begin
      step();
      if (IRWrite) seen = 1;
    end
    check("rst_mid_lo_seen", 32'(seen), 32'd1);
    step();
    check("rst_mid_in_hi", 32'({Busy, MemRead, MemAddr}), 32'({2'b11, 16'h0011}));
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("rst_mid_state", 32'({PC, MemRead, IRWrite, Done, Busy}), 32'({16'h0000, 4'b0000}));
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (IRWrite || Done || MemRead) seen++;
    end
    check("rst_mid_quiet", 32'({seen[7:0], PC}), 32'({8'd0, 16'h0000}));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
